// File: rtl/bcd_seek_sequencer.sv
// Seek sequencer for a mode-driven BCD digit counter: plans a short path from the
// mirrored counter value to a requested digit and issues one mode/step per update.
module bcd_seek_sequencer #(
  parameter int unsigned STEP_GAP = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] target,
  input  logic       sync_load,
  input  logic [3:0] sync_val,
  output logic [1:0] mode,
  output logic       step,
  output logic [3:0] mirror,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DW = 4;
  localparam int unsigned GW = 4;
  localparam int unsigned XW = DW + 1;

  localparam logic [1:0] MODE_ADD1 = 2'b00;
  localparam logic [1:0] MODE_ADD2 = 2'b01;
  localparam logic [1:0] MODE_SUB1 = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_next;
  logic [DW-1:0]  tgt, tgt_next;
  logic           dir_bwd, dir_bwd_next;
  logic [GW-1:0]  gap_cnt, gap_cnt_next;
  logic [DW-1:0]  mirror_next;
  logic [1:0]     mode_next;
  logic           step_next;
  logic           ready_next;
  logic           busy_next;
  logic           done_next;
  logic           err_next;

  logic [XW-1:0]  fwd_c;
  logic [XW-1:0]  bwd_c;
  logic [DW-1:0]  stepped_c;
  logic           bwd_shorter_c;

  // Forward/backward distances modulo 10 between mirror and the latched target
  always_comb begin
    fwd_c = '0;
    bwd_c = '0;
    if (tgt >= mirror) begin
      fwd_c = XW'(tgt) - XW'(mirror);
      bwd_c = (fwd_c == '0) ? '0 : XW'(10) - fwd_c;
    end else begin
      bwd_c = XW'(mirror) - XW'(tgt);
      fwd_c = XW'(10) - bwd_c;
    end
    bwd_shorter_c = ({bwd_c, 1'b0} < {1'b0, fwd_c});
  end

  // Mirror value after the counter applies the mode currently on the bus
  always_comb begin
    stepped_c = mirror;
    case (mode)
      MODE_ADD1: stepped_c = (mirror == DW'(9)) ? '0 : mirror + DW'(1);
      MODE_ADD2: stepped_c = mirror + DW'(2);
      MODE_SUB1: stepped_c = (mirror == '0) ? DW'(9) : mirror - DW'(1);
      default:   stepped_c = mirror;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tgt     <= '0;
      dir_bwd <= 1'b0;
      gap_cnt <= '0;
      mirror  <= '0;
      mode    <= MODE_NONE;
      step    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      tgt     <= tgt_next;
      dir_bwd <= dir_bwd_next;
      gap_cnt <= gap_cnt_next;
      mirror  <= mirror_next;
      mode    <= mode_next;
      step    <= step_next;
      ready   <= ready_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    tgt_next     = tgt;
    dir_bwd_next = dir_bwd;
    gap_cnt_next = gap_cnt;
    mirror_next  = mirror;
    mode_next    = MODE_NONE;
    step_next    = 1'b0;
    ready_next   = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (target > DW'(9)) begin
            err_next = 1'b1;
          end else begin
            tgt_next   = target;
            state_next = CALC;
          end
        end else if (sync_load) begin
          mirror_next = (sync_val > DW'(9)) ? DW'(9) : sync_val;
        end
      end
      CALC: begin
        if (fwd_c == '0) begin
          state_next = DONE;
        end else begin
          dir_bwd_next = bwd_shorter_c;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        mirror_next = stepped_c;
        if (stepped_c == tgt) begin
          state_next = DONE;
        end else begin
          gap_cnt_next = GW'(STEP_GAP - 1);
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_next = ISSUE;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered outputs describe the state being entered; mirror is stable on ISSUE entry
    if (state_next == ISSUE) begin
      step_next = 1'b1;
      if (dir_bwd_next) begin
        mode_next = MODE_SUB1;
      end else if ((fwd_c >= XW'(2)) && (mirror <= DW'(7))) begin
        mode_next = MODE_ADD2;
      end else begin
        mode_next = MODE_ADD1;
      end
    end
    done_next  = (state_next == DONE);
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
  end

endmodule

// File: tb/tb_bcd_seek_sequencer.sv
// Scoreboard bench for bcd_seek_sequencer: a path model queues expected strobes,
// a negedge monitor pops and compares them as the DUT issues steps.
module tb_bcd_seek_sequencer;

  localparam int unsigned G = 2;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] target;
  logic       sync_load;
  logic [3:0] sync_val;
  logic [1:0] mode;
  logic       step;
  logic [3:0] mirror;
  logic       ready;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int strobe_cnt = 0;
  bit mir_pend = 0;
  int mir_exp = 0;
  int mon_e;

  bcd_seek_sequencer #(.STEP_GAP(G)) dut (
    .CLK(CLK), .reset(reset), .start(start), .target(target),
    .sync_load(sync_load), .sync_val(sync_val), .mode(mode), .step(step),
    .mirror(mirror), .ready(ready), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference path planner: pushes mode*16+mirror_after per strobe, returns strobe count
  function automatic int plan(input int m, input int t);
    int fwd, bwd, rem, md, n;
    bit bw;
    n = 0;
    fwd = (t - m + 10) % 10;
    bwd = (m - t + 10) % 10;
    if (fwd == 0) return 0;
    bw = (2 * bwd) < fwd;
    while (m != t) begin
      rem = (t - m + 10) % 10;
      if (bw) begin
        md = 2; m = (m + 9) % 10;
      end else if (rem >= 2 && m <= 7) begin
        md = 1; m = m + 2;
      end else begin
        md = 0; m = (m + 1) % 10;
      end
      exp_q.push_back(md * 16 + m);
      n++;
    end
    return n;
  endfunction

  always @(negedge CLK) begin
    if (!reset) begin
      exp_q.delete();
      mir_pend = 0;
    end else begin
      if (mir_pend) begin
        check("mirror_after_step", mirror, mir_exp);
        mir_pend = 0;
      end
      if (step) begin
        strobe_cnt++;
        check("add2_from_8_9", (mode == 2'b01 && mirror >= 4'd8), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_mode", mode, mon_e / 16);
          mir_exp = mon_e % 16;
          mir_pend = 1;
        end
      end else begin
        check("idle_mode", mode, 3);
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_mode", mode, 3);
    check("rst_step", step, 0);
    check("rst_mirror", mirror, 0);
    check("rst_ready_busy", {ready, busy}, 2'b10);
    check("rst_done_err", {done, err}, 2'b00);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic do_sync(input int v);
    @(posedge CLK); #1;
    sync_load = 1'b1; sync_val = 4'(v);
    @(posedge CLK); #1;
    sync_load = 1'b0;
    @(negedge CLK);
    check("sync_mirror", mirror, (v > 9) ? 9 : v);
  endtask

  // kind: 0 plain, 1 start+sync together, 2 noise inputs during GAP, 3 reset during GAP
  task automatic seek(input int m0, input int t, input int kind);
    int s, done_n, first_n, got_n;
    @(posedge CLK); #1;
    s = plan(m0, t);
    strobe_cnt = 0;
    start = 1'b1; target = 4'(t);
    if (kind == 1) begin sync_load = 1'b1; sync_val = 4'd9; end
    @(posedge CLK); #1;
    start = 1'b0; sync_load = 1'b0;
    done_n = (s == 0) ? 2 : 2 + (s - 1) * (G + 1) + 1;
    first_n = -1;
    got_n = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (step && first_n < 0) first_n = n;
      if (n == 1) check("calc_cycle", {busy, ready, step}, 3'b100);
      if (kind == 2 && n == 3) begin
        start = 1'b1; target = 4'd2; sync_load = 1'b1; sync_val = 4'd8;
      end
      if (kind == 2 && n == 4) begin
        start = 1'b0; sync_load = 1'b0;
      end
      if (kind == 3 && n == 3) begin
        reset = 1'b0;
        #1;
        check("abort_step", step, 0);
        check("abort_mirror", mirror, 0);
        check("abort_mode", mode, 3);
        check("abort_ready_busy", {ready, busy}, 2'b10);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        return;
      end
      if (done) begin
        got_n = n;
        break;
      end
    end
    check("first_strobe_cycle", first_n, (s == 0) ? -1 : 2);
    check("done_cycle", got_n, done_n);
    check("strobe_count", strobe_cnt, s);
    @(negedge CLK);
    check("done_one_cycle", done, 0);
    check("ready_after_done", {ready, busy}, 2'b10);
    check("final_mirror", mirror, t);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target = '0; sync_load = 1'b0; sync_val = '0;
    #2;
    apply_reset();

    seek(0, 5, 0);

    do_sync(5);
    seek(5, 3, 0);

    do_sync(7);
    seek(7, 1, 0);

    // Out-of-range target: err for one cycle, nothing else moves
    @(posedge CLK); #1;
    start = 1'b1; target = 4'd12;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("err_pulse", err, 1);
    check("err_stays_idle", {ready, busy}, 2'b10);
    @(negedge CLK);
    check("err_one_cycle", err, 0);
    check("err_mirror", mirror, 1);

    seek(1, 1, 0);
    seek(1, 2, 1);
    do_sync(12);
    seek(9, 0, 0);
    seek(0, 8, 0);

    apply_reset();
    seek(0, 5, 2);
    seek(5, 9, 3);
    seek(0, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
